// File: rtl/io_bus_master_if.sv
// rtl/io_bus_master_if.sv - CPU request/response channel of io_bus_master, plus shared bus width and ctrl-bit macros
`ifndef IO_BUS_WIDTH_ADDR
`define IO_BUS_WIDTH_ADDR 32
`endif
`ifndef IO_BUS_WIDTH_DATA
`define IO_BUS_WIDTH_DATA 32
`endif
`ifndef IO_BUS_WIDTH_CTRL
`define IO_BUS_WIDTH_CTRL 4
`endif
`ifndef IO_BUS_CTRL_WE
`define IO_BUS_CTRL_WE 0
`define IO_BUS_CTRL_TYPE_B 1
`define IO_BUS_CTRL_TYPE_HB 2
`define IO_BUS_CTRL_UNSIGNED 3
`define IO_CTRL_WRITE 1'b1
`define IO_CTRL_READ 1'b0
`endif

interface io_bus_master_if;
   logic                          req_valid;
   logic                          req_ready;
   logic                          req_we;
   logic [`IO_BUS_WIDTH_ADDR-1:0] req_addr;
   logic [`IO_BUS_WIDTH_DATA-1:0] req_wdata;
   logic [1:0]                    req_size;
   logic                          req_unsigned;
   logic                          resp_valid;
   logic [`IO_BUS_WIDTH_DATA-1:0] resp_rdata;
   logic                          resp_err;

   // Bus-master side: takes requests, returns responses.
   modport master (
      input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
      output req_ready, resp_valid, resp_rdata, resp_err
   );

   // CPU side: issues requests, consumes responses.
   modport slave (
      output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/io_bus_master.sv
// rtl/io_bus_master.sv - Single-outstanding CPU-to-IO bus master with BR/BG arbitration; optional grant timeout under IO_MASTER_TIMEOUT_EN
`ifndef IO_BUS_WIDTH_ADDR
`define IO_BUS_WIDTH_ADDR 32
`endif
`ifndef IO_BUS_WIDTH_DATA
`define IO_BUS_WIDTH_DATA 32
`endif
`ifndef IO_BUS_WIDTH_CTRL
`define IO_BUS_WIDTH_CTRL 4
`endif
`ifndef IO_BUS_CTRL_WE
`define IO_BUS_CTRL_WE 0
`define IO_BUS_CTRL_TYPE_B 1
`define IO_BUS_CTRL_TYPE_HB 2
`define IO_BUS_CTRL_UNSIGNED 3
`define IO_CTRL_WRITE 1'b1
`define IO_CTRL_READ 1'b0
`endif

module io_bus_master #(
   parameter int TIMEOUT = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   io_bus_master_if.master               cpu,
   output logic                          BR,
   input  logic                          BG,
   output wire  [`IO_BUS_WIDTH_ADDR-1:0] addr,
   output wire  [`IO_BUS_WIDTH_CTRL-1:0] ctrl,
   inout  wire  [`IO_BUS_WIDTH_DATA-1:0] data
);
   localparam int AW = `IO_BUS_WIDTH_ADDR;
   localparam int DW = `IO_BUS_WIDTH_DATA;
   localparam int CW = `IO_BUS_WIDTH_CTRL;

   typedef enum logic [1:0] {IDLE, ARB, XFER, DONE} state_t;

   state_t          state_q, state_d;
   logic            we_q, we_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic [1:0]      size_q, size_d;
   logic            uns_q, uns_d;
   logic            err_q, err_d;
   logic [DW-1:0]   rdata_q, rdata_d;
   logic            illegal;
   logic [CW-1:0]   ctrl_v;

`ifdef IO_MASTER_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT;
`endif

   // Misaligned accesses and the reserved size code never reach the bus.
   always_comb begin
      illegal = 1'b0;
      case (cpu.req_size)
         2'b00:   illegal = 1'b0;
         2'b01:   illegal = cpu.req_addr[0];
         2'b10:   illegal = (cpu.req_addr[1:0] != 2'b00);
         default: illegal = 1'b1;
      endcase
   end

   // State and latched-request registers; reset aborts any transfer silently.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         size_q  <= 2'b00;
         uns_q   <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
`ifdef IO_MASTER_TIMEOUT_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
`ifdef IO_MASTER_TIMEOUT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   // Next-state: accept in IDLE, wait for grant in ARB, one-beat transfer in XFER.
   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      size_d  = size_q;
      uns_d   = uns_q;
      err_d   = err_q;
      rdata_d = rdata_q;
`ifdef IO_MASTER_TIMEOUT_EN
      cnt_d   = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (cpu.req_valid) begin
               we_d    = cpu.req_we;
               addr_d  = cpu.req_addr;
               wdata_d = cpu.req_wdata;
               size_d  = cpu.req_size;
               uns_d   = cpu.req_unsigned;
               rdata_d = '0;
               err_d   = illegal;
               state_d = illegal ? DONE : ARB;
`ifdef IO_MASTER_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end
         end
         ARB: begin
            if (BG) begin
               state_d = XFER;
            end else begin
`ifdef IO_MASTER_TIMEOUT_EN
               if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                  err_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
`endif
            end
         end
         XFER: begin
            if (BG) begin
               rdata_d = we_q ? '0 : data;
               state_d = DONE;
            end else begin
               // Grant lost mid-beat: nothing captured, re-arbitrate from scratch.
               state_d = ARB;
`ifdef IO_MASTER_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Control word presented on the bus during XFER.
   always_comb begin
      ctrl_v                         = '0;
      ctrl_v[`IO_BUS_CTRL_WE]        = we_q ? `IO_CTRL_WRITE : `IO_CTRL_READ;
      ctrl_v[`IO_BUS_CTRL_TYPE_B]    = (size_q == 2'b01);
      ctrl_v[`IO_BUS_CTRL_TYPE_HB]   = (size_q == 2'b10);
      ctrl_v[`IO_BUS_CTRL_UNSIGNED]  = uns_q;
   end

   assign cpu.req_ready  = (state_q == IDLE);
   assign cpu.resp_valid = (state_q == DONE);
   assign cpu.resp_err   = (state_q == DONE) & err_q;
   assign cpu.resp_rdata = rdata_q;
   assign BR             = (state_q == ARB) || (state_q == XFER);

   assign addr = (state_q == XFER)         ? addr_q  : {AW{1'bz}};
   assign ctrl = (state_q == XFER)         ? ctrl_v  : {CW{1'bz}};
   assign data = (state_q == XFER && we_q) ? wdata_q : {DW{1'bz}};
endmodule

// File: tb/tb_io_bus_master.sv
// tb/tb_io_bus_master.sv - Scoreboard testbench for io_bus_master
`ifndef IO_BUS_WIDTH_ADDR
`define IO_BUS_WIDTH_ADDR 32
`endif
`ifndef IO_BUS_WIDTH_DATA
`define IO_BUS_WIDTH_DATA 32
`endif
`ifndef IO_BUS_WIDTH_CTRL
`define IO_BUS_WIDTH_CTRL 4
`endif
`ifndef IO_BUS_CTRL_WE
`define IO_BUS_CTRL_WE 0
`define IO_BUS_CTRL_TYPE_B 1
`define IO_BUS_CTRL_TYPE_HB 2
`define IO_BUS_CTRL_UNSIGNED 3
`define IO_CTRL_WRITE 1'b1
`define IO_CTRL_READ 1'b0
`endif

module tb_io_bus_master;
   localparam int AW = `IO_BUS_WIDTH_ADDR;
   localparam int DW = `IO_BUS_WIDTH_DATA;
   localparam int CW = `IO_BUS_WIDTH_CTRL;

   typedef enum int {P_NONE, P_ARB, P_XFER} ph_t;
   typedef struct {
      logic          err;
      logic [DW-1:0] rdata;
      int            lat;
      bit            legal;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          BG;
   logic          BR;
   wire  [AW-1:0] addr;
   wire  [CW-1:0] ctrl;
   wire  [DW-1:0] data;
   logic          slave_en;
   logic [DW-1:0] slave_val;

   io_bus_master_if cpu_if ();

   assign data = slave_en ? slave_val : {DW{1'bz}};

   io_bus_master #(.TIMEOUT(16)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .cpu  (cpu_if),
      .BR   (BR),
      .BG   (BG),
      .addr (addr),
      .ctrl (ctrl),
      .data (data)
   );

   always #5 clk = ~clk;

   int            n_vec = 0;
   int            n_fail = 0;
   int            cyc = 0;
   int            acc_cyc = 0;
   int            br_cnt = 0;
   int            br_at_resp = 0;
   bit            bg_s = 1'b0;
   bit            bg_rand = 1'b0;
   ph_t           ph = P_NONE;
   exp_t          sb_q[$];
   bit            cur_we;
   logic [AW-1:0] cur_addr;
   logic [DW-1:0] cur_wdata;
   logic [CW-1:0] cur_ctrl;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [CW-1:0] exp_ctrl(input bit we, input logic [1:0] sz, input bit uns);
      logic [CW-1:0] c;
      c = '0;
      c[`IO_BUS_CTRL_WE]       = we ? `IO_CTRL_WRITE : `IO_CTRL_READ;
      c[`IO_BUS_CTRL_TYPE_B]   = (sz == 2'd1);
      c[`IO_BUS_CTRL_TYPE_HB]  = (sz == 2'd2);
      c[`IO_BUS_CTRL_UNSIGNED] = uns;
      return c;
   endfunction

   always @(posedge clk) begin
      cyc  <= cyc + 1;
      bg_s <= BG;
   end

   always @(negedge clk) begin
      if (bg_rand) BG = ($urandom_range(0, 3) != 0);
   end

   // Monitor: tracks the BR/BG handshake, checks bus contents and pops responses.
   always @(negedge clk) begin
      bit az, cz;
      exp_t e;
      if (!rst_n) begin
         ph = P_NONE;
      end else begin
         if (!BR)                       ph = P_NONE;
         else if (ph == P_ARB && bg_s)  ph = P_XFER;
         else                           ph = P_ARB;
         if (BR) br_cnt++;
         if (ph == P_XFER) begin
            chk("xfer_addr", 32'(addr), 32'(cur_addr));
            chk("xfer_ctrl", 32'(ctrl), 32'(cur_ctrl));
            chk("xfer_data", 32'(data), cur_we ? 32'(cur_wdata) : 32'(slave_val));
         end else if (ph == P_ARB) begin
            az = (addr === {AW{1'bz}});
            cz = (ctrl === {CW{1'bz}});
            chk("arb_addr_z", 32'(az), 32'd1);
            chk("arb_ctrl_z", 32'(cz), 32'd1);
         end
         if (cpu_if.resp_valid) begin
            br_at_resp = br_cnt;
            if (sb_q.size() == 0) begin
               chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
               e = sb_q.pop_front();
               chk("resp_err", 32'(cpu_if.resp_err), 32'(e.err));
               chk("resp_rdata", 32'(cpu_if.resp_rdata), 32'(e.rdata));
               if (e.lat >= 0) chk("resp_latency", 32'(cyc - acc_cyc), 32'(e.lat));
               if (!e.legal) chk("illegal_no_br", 32'(br_cnt), 32'd0);
            end
         end
      end
   end

   // Issue one request when ready; the expected response is derived from the request alone.
   task automatic issue(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input logic [1:0] sz, input bit uns, input logic [DW-1:0] sv,
                        input int lat, input bit to_err);
      exp_t e;
      bit   legal;
      int   w;
      w = 0;
      while (!cpu_if.req_ready && w < 200) begin
         @(negedge clk);
         w++;
      end
      if (!cpu_if.req_ready) begin
         chk("issue_ready_timeout", 32'd0, 32'd1);
         return;
      end
      legal = (sz == 2'd0) || (sz == 2'd1 && (a % 2) == 0) || (sz == 2'd2 && (a % 4) == 0);
      e.legal = legal;
      e.err   = !legal || to_err;
      e.rdata = (!legal || to_err || we) ? '0 : sv;
      e.lat   = legal ? lat : 0;
      sb_q.push_back(e);
      cur_we    = we;
      cur_addr  = a;
      cur_wdata = wd;
      cur_ctrl  = exp_ctrl(we, sz, uns);
      slave_en  = !we;
      slave_val = sv;
      acc_cyc   = cyc + 1;
      br_cnt    = 0;
      cpu_if.req_valid    = 1'b1;
      cpu_if.req_we       = we;
      cpu_if.req_addr     = a;
      cpu_if.req_wdata    = wd;
      cpu_if.req_size     = sz;
      cpu_if.req_unsigned = uns;
      @(negedge clk);
      cpu_if.req_valid    = 1'b0;
      cpu_if.req_we       = 1'($urandom);
      cpu_if.req_addr     = $urandom;
      cpu_if.req_wdata    = $urandom;
      cpu_if.req_size     = 2'($urandom);
      cpu_if.req_unsigned = 1'($urandom);
   endtask

   task automatic drain();
      int w;
      w = 0;
      while (sb_q.size() != 0 && w < 300) begin
         @(negedge clk);
         w++;
      end
      if (sb_q.size() != 0) chk("drain_timeout", 32'(sb_q.size()), 32'd0);
      @(negedge clk);
   endtask

   task automatic wait_xfer();
      int w;
      w = 0;
      while (ph != P_XFER && w < 50) begin
         @(negedge clk);
         #1;
         w++;
      end
      if (ph != P_XFER) chk("wait_xfer_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      bit az, cz, dz;
      rst_n = 1'b0;
      BG = 1'b0;
      slave_en = 1'b0;
      slave_val = '0;
      cpu_if.req_valid = 1'b0;
      cpu_if.req_we = 1'b0;
      cpu_if.req_addr = '0;
      cpu_if.req_wdata = '0;
      cpu_if.req_size = 2'b00;
      cpu_if.req_unsigned = 1'b0;
      repeat (3) @(negedge clk);
      az = (addr === {AW{1'bz}});
      cz = (ctrl === {CW{1'bz}});
      dz = (data === {DW{1'bz}});
      chk("rst_br", 32'(BR), 32'd0);
      chk("rst_resp_valid", 32'(cpu_if.resp_valid), 32'd0);
      chk("rst_resp_err", 32'(cpu_if.resp_err), 32'd0);
      chk("rst_resp_rdata", 32'(cpu_if.resp_rdata), 32'd0);
      chk("rst_addr_z", 32'(az), 32'd1);
      chk("rst_ctrl_z", 32'(cz), 32'd1);
      chk("rst_data_z", 32'(dz), 32'd1);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_req_ready", 32'(cpu_if.req_ready), 32'd1);

      // Word write, grant already present.
      BG = 1'b1;
      issue(1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0, 32'h0, 2, 1'b0);
      drain();
      // Signed byte read; slave returns pre-extended data.
      issue(1'b0, 32'h13, 32'h0, 2'd0, 1'b0, 32'hFFFFFF80, 2, 1'b0);
      drain();
      // Misaligned half-word read.
      issue(1'b0, 32'h01, 32'h0, 2'd1, 1'b1, 32'h12345678, 0, 1'b0);
      drain();

      // Grant withheld.
      BG = 1'b0;
`ifdef IO_MASTER_TIMEOUT_EN
      issue(1'b0, 32'h20, 32'h0, 2'd2, 1'b0, 32'hCAFEF00D, -1, 1'b1);
      drain();
      chk("timeout_br_cycles", 32'(br_at_resp), 32'd16);
      chk("timeout_br_low", 32'(BR), 32'd0);
      BG = 1'b1;
`else
      issue(1'b0, 32'h20, 32'h0, 2'd2, 1'b0, 32'hCAFEF00D, -1, 1'b0);
      repeat (39) @(negedge clk);
      chk("no_timeout_br_high", 32'(BR), 32'd1);
      chk("no_timeout_pending", 32'(sb_q.size()), 32'd1);
      BG = 1'b1;
      drain();
`endif

      // Grant lost at the XFER exit edge, then regranted.
      issue(1'b1, 32'h40, 32'h0BADF00D, 2'd2, 1'b1, 32'h0, -1, 1'b0);
      wait_xfer();
      BG = 1'b0;
      @(negedge clk);
      #1;
      chk("grant_lost_br", 32'(BR), 32'd1);
      chk("grant_lost_no_resp", 32'(cpu_if.resp_valid), 32'd0);
      BG = 1'b1;
      drain();

      // Reset pulse in the middle of a transfer.
      issue(1'b1, 32'h80, 32'h55AA55AA, 2'd2, 1'b0, 32'h0, -1, 1'b0);
      wait_xfer();
      #2 rst_n = 1'b0;
      #1;
      az = (addr === {AW{1'bz}});
      cz = (ctrl === {CW{1'bz}});
      dz = (data === {DW{1'bz}});
      chk("xfer_rst_br", 32'(BR), 32'd0);
      chk("xfer_rst_addr_z", 32'(az), 32'd1);
      chk("xfer_rst_ctrl_z", 32'(cz), 32'd1);
      chk("xfer_rst_data_z", 32'(dz), 32'd1);
      chk("xfer_rst_resp_valid", 32'(cpu_if.resp_valid), 32'd0);
      sb_q.delete();
      slave_en = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("xfer_rst_req_ready", 32'(cpu_if.req_ready), 32'd1);
      repeat (4) @(negedge clk);

      // Randomized traffic with a randomly toggling grant.
      bg_rand = 1'b1;
      for (int i = 0; i < 150; i++) begin
         issue(1'($urandom), {24'h0, 8'($urandom)}, $urandom, 2'($urandom),
               1'($urandom), $urandom, -1, 1'b0);
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      bg_rand = 1'b0;
      BG = 1'b1;
      drain();
      chk("final_queue_empty", 32'(sb_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got running expected done");
      $fatal(1);
   end
endmodule

// File: doc/io_bus_master.md
IO_BUS_MASTER -- requirements
Module: io_bus_master

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum cycles spent waiting for BG before an error response.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  1  CPU request present.
REQ-005 req_ready  output  1  master can accept a request; high only in IDLE.
REQ-006 req_we  input  1  1 = write, 0 = read.
REQ-007 req_addr  input  `IO_BUS_WIDTH_ADDR  byte address.
REQ-008 req_wdata  input  `IO_BUS_WIDTH_DATA  write value, right-aligned.
REQ-009 req_size  input  2  00 byte, 01 half-word, 10 word, 11 illegal.
REQ-010 req_unsigned  input  1  zero-extend (1) or sign-extend (0) read data.
REQ-011 resp_valid  output  1  one-cycle response strobe.
REQ-012 resp_rdata  output  `IO_BUS_WIDTH_DATA  read result; 0 after writes and errors.
REQ-013 resp_err  output  1  error flag, qualified by resp_valid.
REQ-014 BR  output  1  bus request to arbiter.
REQ-015 BG  input  1  bus grant from arbiter.
REQ-016 addr  output  `IO_BUS_WIDTH_ADDR  bus address; high-Z unless in XFER.
REQ-017 ctrl  output  `IO_BUS_WIDTH_CTRL  bus control; high-Z unless in XFER.
REQ-018 data  inout  `IO_BUS_WIDTH_DATA  bus data; driven only in XFER with a write, otherwise high-Z.

Function
REQ-019 Four states: IDLE, ARB, XFER, DONE.
REQ-020 IDLE: on an edge with req_valid=1, latch all req_* fields.
- Illegal request (size 11; half-word with addr[0]=1; word with addr[1:0]!=0): go to DONE with err=1, no BR.
- Legal request: go to ARB.
REQ-021 ARB: BR=1; on an edge sampling BG=1, go to XFER.
REQ-022 XFER: BR=1; drive addr, ctrl and write data.
- ctrl[`IO_BUS_CTRL_WE] = `IO_CTRL_WRITE for writes, `IO_CTRL_READ for reads.
- Size encoding: byte = TYPE_B=0 and TYPE_HB=0; half-word = TYPE_B=1 and TYPE_HB=0; word = TYPE_HB=1.
- ctrl[`IO_BUS_CTRL_UNSIGNED] = latched req_unsigned; all other ctrl bits 0.
REQ-023 XFER exit edge:
- BG=1: capture data into resp_rdata (reads only; writes load 0) and go to DONE.
- BG=0 (grant lost): go back to ARB, no capture, and retry.
REQ-024 DONE: resp_valid=1 for exactly one cycle, BR=0, then go to IDLE.
REQ-025 Minimum latency: request accepted at edge N, BG already high gives XFER after N+1 and resp_valid high in the cycle after edge N+2.
REQ-026 Read data is taken unmodified from the bus; the slave performs lane selection and extension.
REQ-027 req_ready=0 outside IDLE; requests are not queued, and req_* changes outside IDLE are ignored.
REQ-028 BR drops in the cycle after DONE is entered; back-to-back requests re-arbitrate.

Reset
REQ-029 While rst_n=0, immediately (asynchronously):
- state goes to IDLE;
- BR=0, resp_valid=0, resp_err=0, resp_rdata=0;
- addr, ctrl and data go high-Z.
REQ-030 Reset during ARB or XFER aborts the transfer and produces no response.

Configuration
REQ-031 With IO_MASTER_TIMEOUT_EN defined, a counter cleared on ARB entry increments each ARB cycle with BG=0.
- On reaching TIMEOUT, go to DONE with resp_err=1 and BR=0.
REQ-032 Without IO_MASTER_TIMEOUT_EN, ARB waits for BG indefinitely, the counter is absent, and resp_err only flags illegal requests.

Verification
REQ-033 Word write, addr 0x10, wdata 0xDEADBEEF, BG tied 1: one XFER cycle with data=0xDEADBEEF and the WE bit at WRITE; resp_valid with err=0 and rdata=0.
REQ-034 Signed byte read, addr 0x13, slave returns 0xFFFFFF80: resp_rdata=0xFFFFFF80; ctrl TYPE_B=0, TYPE_HB=0, UNSIGNED=0; data high-Z during XFER.
REQ-035 Half-word read at addr 0x01: no BR assertion; resp_valid with err=1 in the cycle after acceptance.
REQ-036 BG held 0 with the macro defined and TIMEOUT=16: BR high for 16 cycles, then resp_err=1 and BR=0; without the macro, BR stays high.
REQ-037 BG drops at the XFER exit edge: return to ARB; regrant completes normally with a single resp_valid.
REQ-038 rst_n pulsed low during XFER: bus high-Z and BR=0 immediately; no resp_valid; req_ready=1 after release.
